// File: rtl/mrav_core_gen2.sv
// mrav_core_gen2: multicycle core fetching 16-bit instructions over a request/done bus
// with a per-transaction wait counter that halts the core on bus timeout.
module mrav_core_gen2 #(
  parameter int MRAV_DATA_WIDTH = 16,
  parameter int MRAV_ADDR_WIDTH = 16,
  parameter logic [MRAV_ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       read,
  output logic                       write,
  input  logic                       read_done,
  input  logic                       write_done,
  output logic [MRAV_ADDR_WIDTH-1:0] addr,
  output logic [MRAV_DATA_WIDTH-1:0] data_out,
  input  logic [MRAV_DATA_WIDTH-1:0] data_in,
  output logic                       retired,
  output logic                       halted,
  output logic                       bus_err
);
  localparam int DW = MRAV_DATA_WIDTH;
  localparam int AW = MRAV_ADDR_WIDTH;
  localparam int CW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_AND = 4'd3,
                         OP_OR = 4'd4, OP_ADDI = 4'd5, OP_LDHI = 4'd6, OP_SHL = 4'd7,
                         OP_SHR = 4'd8, OP_SHRA = 4'd9, OP_BZ = 4'd10, OP_BNZ = 4'd11,
                         OP_JAL = 4'd12, OP_JALR = 4'd13, OP_LW = 4'd14, OP_SW = 4'd15;
  typedef enum logic [1:0] {FETCH, LW_READ, SW_WRITE, HALT} state_t;
  state_t state, state_n;
  logic [DW-1:0] r [16];
  logic [AW-1:0] pc, pc_n, pc2, pc_j, jr;
  logic [15:0] ir, ins;
  logic [CW-1:0] wcnt;
  logic [3:0] op, rd, rs1, rs2, imm4;
  logic [7:0] imm8;
  logic [DW-1:0] rdv, rs1v, rs2v, alu;
  logic done, tmo, taken, we, fin;
  // The instruction is taken straight off the bus during fetch; bus phases use the latched copy.
  assign ins = state == FETCH ? data_in[15:0] : ir;
  assign {op, rd, rs1, rs2} = ins;
  assign imm8 = ins[7:0];
  assign imm4 = ins[7:4];
  assign rdv = r[rd];
  assign rs1v = r[rs1];
  assign rs2v = r[rs2];
  assign pc2 = pc + AW'(2);
  assign pc_j = pc + {{(AW-9){imm8[7]}}, imm8, 1'b0};
  assign jr = AW'(rs1v) & ~AW'(1);
  assign done = state == SW_WRITE ? write_done : state != HALT && read_done;
  assign tmo = state != HALT && !done && wcnt == CW'(BUS_TIMEOUT);
  assign taken = (op == OP_BZ && rdv == '0) || (op == OP_BNZ && rdv != '0) || op == OP_JAL;
  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = rs1v + rs2v;
      OP_SUB:  alu = rs1v - rs2v;
      OP_XOR:  alu = rs1v ^ rs2v;
      OP_AND:  alu = rs1v & rs2v;
      OP_OR:   alu = rs1v | rs2v;
      OP_ADDI: alu = rdv + {{(DW-8){imm8[7]}}, imm8};
      OP_LDHI: alu = (rdv & ~DW'(16'hFF00)) | (DW'(imm8) << 8);
      OP_SHL:  alu = rdv << imm4;
      OP_SHR:  alu = rdv >> imm4;
      OP_SHRA: alu = $signed(rdv) >>> imm4;
      OP_JAL, OP_JALR: alu = DW'(pc2);
      OP_LW:   alu = data_in;
      default: alu = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      wcnt <= '0;
      bus_err <= 1'b0;
      retired <= 1'b0;
      for (int i = 0; i < 16; i++) r[i] <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      retired <= fin;
      wcnt <= (done || tmo || state == HALT) ? '0 : wcnt + 1'b1;
      if (done && state == FETCH) ir <= data_in[15:0];
      if (tmo) bus_err <= 1'b1;
      if (we && rd != 4'd0) r[rd] <= alu;
    end
  end
  always_comb begin
    state_n = state;
    pc_n = pc;
    we = 1'b0;
    fin = 1'b0;
    if (tmo) state_n = HALT;
    else if (done && state == FETCH) begin
      state_n = op == OP_LW ? LW_READ : op == OP_SW ? SW_WRITE : FETCH;
      we = op != OP_BZ && op != OP_BNZ && op != OP_LW && op != OP_SW;
      fin = state_n == FETCH;
      pc_n = taken ? pc_j : op == OP_JALR ? jr : state_n == FETCH ? pc2 : pc;
    end else if (done) begin
      state_n = FETCH;
      we = state == LW_READ;
      fin = 1'b1;
      pc_n = pc2;
    end
  end
  always_comb begin
    read = !rst && (state == FETCH || state == LW_READ);
    write = !rst && state == SW_WRITE;
    halted = state == HALT;
    addr = state == FETCH ? pc : state == LW_READ ? AW'(rs1v) : state == SW_WRITE ? AW'(rdv) : '0;
    data_out = state == SW_WRITE ? rs1v : '0;
  end
endmodule

// File: tb/tb_mrav_core_gen2.sv
// tb_mrav_core_gen2: program table with expected next-pc per retirement, a store scoreboard
// checked against the bus, plus hand sequences for timeout, halt and mid-transaction reset.
module tb_mrav_core_gen2;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst, read, write, read_done, write_done, retired, halted, bus_err;
  logic [15:0] addr, data_out, data_in;
  always #5 clk = ~clk;
  mrav_core_gen2 #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .read_done(read_done),
    .write_done(write_done), .addr(addr), .data_out(data_out), .data_in(data_in),
    .retired(retired), .halted(halted), .bus_err(bus_err)
  );
  typedef struct { logic [15:0] pc, ins, npc; } vec_t;
  typedef struct { logic [15:0] a, d; } st_t;
  vec_t vt[$];
  st_t sb[$];
  logic [15:0] mem [0:32767];
  int n_vec = 0, n_mis = 0, rcount = 0;
  logic mute_r = 1'b0, mute_w = 1'b0, chkw = 1'b1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic add(input logic [15:0] pc, ins, npc, input logic sw = 1'b0,
                     input logic [15:0] ea = '0, ed = '0);
    vec_t v;
    st_t s;
    v.pc = pc; v.ins = ins; v.npc = npc;
    vt.push_back(v);
    mem[pc[15:1]] = ins;
    if (sw) begin
      s.a = ea; s.d = ed;
      sb.push_back(s);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (retired) rcount++;
  end
  // Bus memory: reads answer at once, writes after three wait cycles.
  initial begin
    int wc;
    wc = 0;
    read_done = 1'b0; write_done = 1'b0; data_in = '0;
    forever begin
      @(posedge clk); #1;
      read_done = 1'b0; write_done = 1'b0;
      if (read && !mute_r) begin
        read_done = 1'b1;
        data_in = mem[addr[15:1]];
        wc = 0;
      end else if (write && !mute_w) begin
        if (chkw) begin
          if (sb.size() == 0) begin
            n_vec++; n_mis++;
            $display("FAIL sw_unexpected: got addr %h data %h expected no store", addr, data_out);
          end else begin
            chk("sw_addr", 32'(addr), 32'(sb[0].a));
            chk("sw_data", 32'(data_out), 32'(sb[0].d));
          end
        end
        if (wc == 3) begin
          write_done = 1'b1;
          mem[addr[15:1]] = data_out;
          if (chkw && sb.size() > 0) void'(sb.pop_front());
          wc = 0;
        end else wc++;
      end else wc = 0;
    end
  end
  initial begin
    int n, r0c;
    logic got;
    for (int i = 0; i < 32768; i++) mem[i] = '0;
    add(16'h0000, 16'h5105, 16'h0002);
    add(16'h0002, 16'h52FF, 16'h0004);
    add(16'h0004, 16'h0312, 16'h0006);
    add(16'h0006, 16'h5012, 16'h0008);
    add(16'h0008, 16'h6401, 16'h000A);
    add(16'h000A, 16'hF430, 16'h000C, 1'b1, 16'h0100, 16'h0004);
    add(16'h000C, 16'h5402, 16'h000E);
    add(16'h000E, 16'hF400, 16'h0010, 1'b1, 16'h0102, 16'h0000);
    add(16'h0010, 16'h5402, 16'h0012);
    add(16'h0012, 16'hF420, 16'h0014, 1'b1, 16'h0104, 16'hFFFF);
    add(16'h0014, 16'hC003, 16'h001A);
    add(16'h001A, 16'hB1FE, 16'h0016);
    add(16'h0016, 16'hC003, 16'h001C);
    add(16'h001C, 16'hA1FE, 16'h001E);
    add(16'h001E, 16'hA003, 16'h0024);
    add(16'h0024, 16'h6680, 16'h0026);
    add(16'h0026, 16'h9630, 16'h0028);
    add(16'h0028, 16'h6501, 16'h002A);
    add(16'h002A, 16'h5506, 16'h002C);
    add(16'h002C, 16'hF560, 16'h002E, 1'b1, 16'h0106, 16'hF000);
    add(16'h002E, 16'h7140, 16'h0030);
    add(16'h0030, 16'h8280, 16'h0032);
    add(16'h0032, 16'h2712, 16'h0034);
    add(16'h0034, 16'h5502, 16'h0036);
    add(16'h0036, 16'hF570, 16'h0038, 1'b1, 16'h0108, 16'h00AF);
    add(16'h0038, 16'h1812, 16'h003A);
    add(16'h003A, 16'h3982, 16'h003C);
    add(16'h003C, 16'h4A96, 16'h003E);
    add(16'h003E, 16'h5502, 16'h0040);
    add(16'h0040, 16'hF580, 16'h0042, 1'b1, 16'h010A, 16'hFF51);
    add(16'h0042, 16'h5502, 16'h0044);
    add(16'h0044, 16'hF5A0, 16'h0046, 1'b1, 16'h010C, 16'hF051);
    add(16'h0046, 16'hEB50, 16'h0048);
    add(16'h0048, 16'h5B01, 16'h004A);
    add(16'h004A, 16'h5502, 16'h004C);
    add(16'h004C, 16'hF5B0, 16'h004E, 1'b1, 16'h010E, 16'hF052);
    add(16'h004E, 16'hD760, 16'hF000);
    add(16'hF000, 16'h5502, 16'hF002);
    add(16'hF002, 16'hF570, 16'hF004, 1'b1, 16'h0110, 16'h0050);
    add(16'hF004, 16'h6C02, 16'hF006);
    add(16'hF006, 16'hDCC0, 16'h0200);
    add(16'h0200, 16'h5502, 16'h0202);
    add(16'h0202, 16'hF5C0, 16'h0204, 1'b1, 16'h0112, 16'hF008);
    add(16'h0204, 16'h1444, 16'h0206);
    add(16'h0206, 16'h6401, 16'h0208);
    add(16'h0208, 16'h1555, 16'h020A);
    add(16'h020A, 16'h65BF, 16'h020C);
    add(16'h020C, 16'h55EF, 16'h020E);
    add(16'h020E, 16'hF450, 16'h0210, 1'b1, 16'h0100, 16'hBEEF);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("init_read", 32'(read), 32'd1);
    chk("init_addr", 32'(addr), 32'h0);
    chk("init_flags", {write, retired, halted, bus_err}, 32'd0);
    chk("init_dout", 32'(data_out), 32'd0);
    foreach (vt[i]) begin
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(posedge clk); #1;
        got = retired;
      end
      n_vec++;
      if (!got) begin
        n_mis++;
        $display("FAIL retire_timeout pc %h: got no retired expected pulse", vt[i].pc);
      end else begin
        chk($sformatf("npc_%h", vt[i].pc), {read, addr}, {1'b1, vt[i].npc});
        chk($sformatf("rcount_%h", vt[i].pc), rcount, i);
      end
    end
    chk("sb_drained", sb.size(), 0);
    @(negedge clk);
    mute_r = 1'b1;
    read_done = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (halted) break;
      if (read) n++;
    end
    chk("to_wait_cycles", n, TO);
    chk("to_halted", {halted, bus_err, read, write}, 32'b1100);
    @(negedge clk) read_done = 1'b1;
    @(posedge clk); #1;
    chk("halt_ignores_done", {halted, read, retired}, 32'b100);
    mem[0] = 16'hF000;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_from_halt", {read, write, halted, bus_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0; mute_r = 1'b0; mute_w = 1'b1; chkw = 1'b0;
    @(posedge clk); #1;
    chk("restart_fetch", {read, addr}, {1'b1, 16'h0000});
    chk("restart_err", {halted, bus_err}, 32'd0);
    @(posedge clk); #1;
    chk("mid_sw_write", {write, addr}, {1'b1, 16'h0000});
    @(posedge clk);
    @(negedge clk) begin rst = 1'b1; r0c = rcount; end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_fetch", {read, write, addr}, {2'b10, 16'h0000});
    repeat (2) @(negedge clk);
    chk("mid_rst_no_retire", rcount, r0c);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
